commit_arbiter: RTL and testbench

Collects finished results from the core's N execution units (alu0..aluN-1) and selects one per cycle, round-robin, for register-file writeback. It consumes each unit's commit interface (req/valid/res/o_rd/o_error) and acknowledges the selected unit with a one-cycle `clear`. The winner goes into a one-entry writeback register with ready/valid backpressure toward the register file. Error results are routed to an exception port instead of being written.

---
 rtl/core_config_pkg.sv | 22 ++
 rtl/commit_arbiter_rr.sv | 32 +++
 rtl/commit_arbiter.sv | 139 +++++++++++++
 tb/tb_commit_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the commit path.
// Holds widths, unit count and the commit entry layout.
package core_config_pkg;

    localparam int XLEN         = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int COMMIT_UNITS = 4;

    // Writeback register occupancy
    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

    // One committed result; also meant for the future ROB
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic                  error;
    } commit_entry_t;

endpackage

// File: rtl/commit_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above
// the pointer, wrapping around. The pointer register lives outside.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(N);

    // Scan N positions starting at the pointer; the first hit wins
    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(i_ptr) + i) % N;
            if (!o_any && i_req[j]) begin
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/commit_arbiter.sv
// Round-robin commit arbiter feeding a one-entry writeback register.
// Error results are diverted to a one-cycle exception report.
module commit_arbiter #(
    parameter int N_UNITS    = core_config_pkg::COMMIT_UNITS,
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_UNITS-1:0]                  u_req,
    input  logic [N_UNITS-1:0]                  u_valid,
    input  logic [N_UNITS-1:0][XLEN-1:0]        u_res,
    input  logic [N_UNITS-1:0][REG_ADDR_W-1:0]  u_rd,
    input  logic [N_UNITS-1:0]                  u_error,
    output logic [N_UNITS-1:0]                  u_clear,
    output logic                                wb_valid,
    output logic [REG_ADDR_W-1:0]               wb_rd,
    output logic [XLEN-1:0]                     wb_data,
    input  logic                                wb_ready,
    output logic                                exc_valid,
    output logic [$clog2(N_UNITS)-1:0]          exc_unit,
    output logic [REG_ADDR_W-1:0]               exc_rd,
    input  logic                                flush
);

    import core_config_pkg::wb_state_e;
    import core_config_pkg::WB_EMPTY;
    import core_config_pkg::WB_FULL;

    localparam int IW = $clog2(N_UNITS);

    wb_state_e             r_wb_state;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [XLEN-1:0]       r_wb_data;
    logic                  r_exc_valid;
    logic [IW-1:0]         r_exc_unit;
    logic [REG_ADDR_W-1:0] r_exc_rd;
    logic [IW-1:0]         r_rr_ptr;

    logic [N_UNITS-1:0]    w_elig;
    logic [N_UNITS-1:0]    w_gnt;
    logic [IW-1:0]         w_idx;
    logic                  w_any;
    logic                  w_can_accept;
    logic                  w_grant;
    logic                  w_sel_err;
    logic [REG_ADDR_W-1:0] w_sel_rd;
    logic [XLEN-1:0]       w_sel_res;
    logic                  w_load;
    logic [IW-1:0]         w_ptr_nxt;

    assign w_elig = u_req & u_valid;

    rr_arbiter #(
        .N (N_UNITS)
    ) u_rr (
        .i_req (w_elig),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Grant only with room in the writeback slot, no flush, out of reset
    assign w_can_accept = (r_wb_state == WB_EMPTY) | wb_ready;
    assign w_grant      = w_can_accept & w_any & ~flush & rst_n;
    assign u_clear      = w_grant ? w_gnt : '0;

    assign w_sel_err = u_error[w_idx];
    assign w_sel_rd  = u_rd[w_idx];
    assign w_sel_res = u_res[w_idx];

    // Errors and x0 writes are acknowledged but never enter writeback
    assign w_load = w_grant & ~w_sel_err & (w_sel_rd != '0);

    assign w_ptr_nxt = (w_idx == IW'(N_UNITS - 1)) ? '0 : w_idx + IW'(1);

    // Writeback slot FSM with its registered payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_state <= WB_EMPTY;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else if (flush) begin
            r_wb_state <= WB_EMPTY;
        end else begin
            case (r_wb_state)
                WB_EMPTY: begin
                    if (w_load) begin
                        r_wb_state <= WB_FULL;
                        r_wb_rd    <= w_sel_rd;
                        r_wb_data  <= w_sel_res;
                    end
                end
                WB_FULL: begin
                    if (w_load) begin
                        r_wb_rd   <= w_sel_rd;
                        r_wb_data <= w_sel_res;
                    end else if (wb_ready) begin
                        r_wb_state <= WB_EMPTY;
                    end
                end
                default: r_wb_state <= WB_EMPTY;
            endcase
        end
    end

    // One-cycle exception report for a granted error result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_valid <= 1'b0;
            r_exc_unit  <= '0;
            r_exc_rd    <= '0;
        end else begin
            r_exc_valid <= w_grant & w_sel_err;
            if (w_grant && w_sel_err) begin
                r_exc_unit <= w_idx;
                r_exc_rd   <= w_sel_rd;
            end
        end
    end

    // Priority moves just past the last winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    assign wb_valid  = (r_wb_state == WB_FULL);
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign exc_valid = r_exc_valid;
    assign exc_unit  = r_exc_unit;
    assign exc_rd    = r_exc_rd;

endmodule

// File: tb/tb_commit_arbiter.sv
// Bench for commit_arbiter: vector table, directed corner sequences
// and random traffic against a rule-level reference model.
module tb_commit_arbiter;

    localparam int N  = 4;
    localparam int XL = 32;
    localparam int RW = 5;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N-1:0]      valid;
    logic [N-1:0][XL-1:0] res;
    logic [N-1:0][RW-1:0] rd;
    logic [N-1:0]      err;
    logic [N-1:0]      clr;
    logic              wbv;
    logic [RW-1:0]     wbrd;
    logic [XL-1:0]     wbdata;
    logic              ready;
    logic              excv;
    logic [1:0]        excu;
    logic [RW-1:0]     excrd;
    logic              flush;

    int cmp_cnt = 0;
    int bad_cnt = 0;

    commit_arbiter #(.N_UNITS(N), .XLEN(XL), .REG_ADDR_W(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .u_req     (req),
        .u_valid   (valid),
        .u_res     (res),
        .u_rd      (rd),
        .u_error   (err),
        .u_clear   (clr),
        .wb_valid  (wbv),
        .wb_rd     (wbrd),
        .wb_data   (wbdata),
        .wb_ready  (ready),
        .exc_valid (excv),
        .exc_unit  (excu),
        .exc_rd    (excrd),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] valid;
        logic [3:0] err;
        logic [4:0] rd;
        logic       flush;
        logic       ready;
        logic [3:0] eclr;
        logic       ewbv;
        logic [4:0] ewbrd;
        logic       eexc;
        logic [1:0] eunit;
        logic [4:0] erd;
    } vec_t;

    function automatic vec_t mk(
        logic [3:0] rq, logic [3:0] vl, logic [3:0] er, logic [4:0] r,
        logic fl, logic rdy, logic [3:0] ec, logic ev, logic [4:0] er_rd,
        logic ex, logic [1:0] eu, logic [4:0] exrd);
        vec_t v;
        v.req = rq; v.valid = vl; v.err = er; v.rd = r;
        v.flush = fl; v.ready = rdy; v.eclr = ec; v.ewbv = ev;
        v.ewbrd = er_rd; v.eexc = ex; v.eunit = eu; v.erd = exrd;
        return v;
    endfunction

    task automatic set_all(input logic [3:0] rq, input logic [3:0] vl,
                           input logic [3:0] er, input logic [4:0] r,
                           input logic fl, input logic rdy);
        req = rq; valid = vl; err = er; flush = fl; ready = rdy;
        for (int k = 0; k < N; k++) begin
            rd[k]  = r;
            res[k] = 32'hA000_0000 | k;
        end
    endtask

    task automatic do_reset();
        set_all(4'b0, 4'b0, 4'b0, 5'd0, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[12];

    // reference model state
    int          m_ptr;
    bit          m_wbv;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_exc;
    int          m_eu;
    logic [4:0]  m_erd;

    initial begin
        rst_n = 1'b0;
        set_all(4'b0, 4'b0, 4'b0, 5'd0, 1'b0, 1'b1);
        #2;
        chk("rst_clear", clr, 0);
        chk("rst_wbv", wbv, 0);
        chk("rst_wbrd", wbrd, 0);
        chk("rst_wbdata", wbdata, 0);
        chk("rst_exc", excv, 0);
        chk("rst_excu", excu, 0);
        chk("rst_excrd", excrd, 0);
        do_reset();

        // ---- table: applied in order from the reset state
        tbl[0]  = mk(4'b0100, 4'b1111, 4'b0000, 5'd5, 0, 1, 4'b0100, 1, 5'd5, 0, 0, 0);
        tbl[1]  = mk(4'b1111, 4'b1111, 4'b0000, 5'd6, 0, 1, 4'b1000, 1, 5'd6, 0, 0, 0);
        tbl[2]  = mk(4'b1111, 4'b1111, 4'b0000, 5'd6, 0, 1, 4'b0001, 1, 5'd6, 0, 0, 0);
        tbl[3]  = mk(4'b1111, 4'b1111, 4'b0000, 5'd6, 0, 1, 4'b0010, 1, 5'd6, 0, 0, 0);
        tbl[4]  = mk(4'b1111, 4'b0011, 4'b0000, 5'd6, 0, 1, 4'b0001, 1, 5'd6, 0, 0, 0);
        tbl[5]  = mk(4'b1000, 4'b1111, 4'b1000, 5'd7, 0, 1, 4'b1000, 0, 5'd0, 1, 3, 7);
        tbl[6]  = mk(4'b0000, 4'b1111, 4'b0000, 5'd7, 0, 1, 4'b0000, 0, 5'd0, 0, 0, 0);
        tbl[7]  = mk(4'b0001, 4'b1111, 4'b0000, 5'd0, 0, 1, 4'b0001, 0, 5'd0, 0, 0, 0);
        tbl[8]  = mk(4'b0010, 4'b1111, 4'b0000, 5'd9, 0, 1, 4'b0010, 1, 5'd9, 0, 0, 0);
        tbl[9]  = mk(4'b0010, 4'b1111, 4'b0000, 5'd10, 0, 0, 4'b0000, 1, 5'd9, 0, 0, 0);
        tbl[10] = mk(4'b0010, 4'b1111, 4'b0000, 5'd10, 1, 0, 4'b0000, 0, 5'd0, 0, 0, 0);
        tbl[11] = mk(4'b0010, 4'b1111, 4'b0000, 5'd10, 0, 0, 4'b0010, 1, 5'd10, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            set_all(tbl[i].req, tbl[i].valid, tbl[i].err, tbl[i].rd,
                    tbl[i].flush, tbl[i].ready);
            #2;
            chk($sformatf("tbl%0d_clear", i), clr, tbl[i].eclr);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_wbv", i), wbv, tbl[i].ewbv);
            if (tbl[i].ewbv)
                chk($sformatf("tbl%0d_wbrd", i), wbrd, tbl[i].ewbrd);
            chk($sformatf("tbl%0d_exc", i), excv, tbl[i].eexc);
            if (tbl[i].eexc) begin
                chk($sformatf("tbl%0d_excu", i), excu, tbl[i].eunit);
                chk($sformatf("tbl%0d_excrd", i), excrd, tbl[i].erd);
            end
        end

        // ---- single request, then backpressure, then accept+grant
        do_reset();
        set_all(4'b0100, 4'b0100, 4'b0, 5'd0, 1'b0, 1'b1);
        rd[2] = 5'd5; res[2] = 32'hDEADBEEF;
        #2;
        chk("single_clear", clr, 4'b0100);
        @(posedge clk); #1;
        chk("single_wbv", wbv, 1);
        chk("single_wbrd", wbrd, 5);
        chk("single_wbdata", wbdata, 32'hDEADBEEF);
        set_all(4'b0010, 4'b0010, 4'b0, 5'd3, 1'b0, 1'b0);
        res[1] = 32'h0000_0011;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("bp_clear", clr, 0);
            @(posedge clk); #1;
            chk("bp_wbv", wbv, 1);
            chk("bp_wbrd", wbrd, 5);
            chk("bp_wbdata", wbdata, 32'hDEADBEEF);
        end
        ready = 1'b1;
        #2;
        chk("bp_release_clear", clr, 4'b0010);
        @(posedge clk); #1;
        chk("bp_new_wbv", wbv, 1);
        chk("bp_new_wbrd", wbrd, 3);
        chk("bp_new_wbdata", wbdata, 32'h11);

        // ---- flush with a full slot and unit 0 requesting
        set_all(4'b0001, 4'b0001, 4'b0, 5'd4, 1'b0, 1'b0);
        #2;
        chk("fl_pre_clear", clr, 0);
        @(posedge clk); #1;
        chk("fl_pre_wbv", wbv, 1);
        flush = 1'b1;
        #2;
        chk("fl_clear", clr, 0);
        @(posedge clk); #1;
        chk("fl_wbv", wbv, 0);
        flush = 1'b0;
        #2;
        chk("fl_after_clear", clr, 4'b0001);
        @(posedge clk); #1;
        chk("fl_after_wbv", wbv, 1);
        chk("fl_after_wbrd", wbrd, 4);

        // ---- asynchronous reset with the slot full
        set_all(4'b1111, 4'b1111, 4'b0, 5'd8, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_clear", clr, 0);
        chk("ar_wbv", wbv, 0);
        chk("ar_wbrd", wbrd, 0);
        chk("ar_wbdata", wbdata, 0);
        chk("ar_exc", excv, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_ptr0_clear", clr, 4'b0001);

        // ---- random traffic against the reference model
        do_reset();
        m_ptr = 0; m_wbv = 0; m_rd = 0; m_data = 0;
        m_exc = 0; m_eu = 0; m_erd = 0;
        for (int c = 0; c < 400; c++) begin
            logic [3:0] e;
            logic [3:0] eclr;
            bit g;
            int w;
            for (int k = 0; k < N; k++) begin
                rd[k]  = 5'($urandom_range(0, 7));
                res[k] = $urandom;
            end
            req   = 4'($urandom);
            valid = 4'($urandom);
            err   = 4'($urandom) & 4'($urandom) & 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            e = req & valid;
            g = (!m_wbv || ready) && (e != 0) && !flush;
            w = -1;
            if (g)
                for (int i = 0; i < N; i++)
                    if (w < 0 && e[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            eclr = g ? (4'b0001 << w) : 4'b0000;
            #2;
            chk("rnd_clear", clr, eclr);
            m_exc = g && err[w];
            if (m_exc) begin
                m_eu  = w;
                m_erd = rd[w];
            end
            if (flush) m_wbv = 0;
            else if (g && !err[w] && rd[w] != 0) begin
                m_wbv = 1; m_rd = rd[w]; m_data = res[w];
            end else if (ready) m_wbv = 0;
            if (g) m_ptr = (w + 1) % N;
            @(posedge clk); #1;
            chk("rnd_wbv", wbv, m_wbv);
            if (m_wbv) begin
                chk("rnd_wbrd", wbrd, m_rd);
                chk("rnd_wbdata", wbdata, m_data);
            end
            chk("rnd_exc", excv, m_exc);
            if (m_exc) begin
                chk("rnd_excu", excu, m_eu);
                chk("rnd_excrd", excrd, m_erd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
